// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks an active-low row strobe, debounces a single
// pressed key on press and release, and reports it as one-hot row/column.
module keypad_scanner #(
    parameter int SCAN_DIV  = 4800,
    parameter int DB_CYCLES = 240000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] col_n,
    output logic [3:0] row_n,
    output logic [3:0] R_val,
    output logic [3:0] C,
    output logic       key_press,
    output logic       new_key
);

    localparam int DW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int BW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] DB_LAST    = BW'(DB_CYCLES - 1);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

    state_t          state;
    logic [3:0]      sync1, sync2;
    logic [3:0]      col_act;
    logic [3:0]      cand_col;
    logic [1:0]      row_idx;
    logic [DW-1:0]   dwell_cnt;
    logic [BW-1:0]   db_cnt;
    logic            col_single;
    logic            cand_hit;

    assign col_act    = ~sync2;
    assign col_single = (col_act != 4'b0000) && ((col_act & (col_act - 4'd1)) == 4'b0000);
    assign cand_hit   = |(col_act & cand_col);

    function automatic logic [3:0] row_drive(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

    // Columns are asynchronous to clk; idle (pulled-up) value is all ones.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1 <= 4'b1111;
            sync2 <= 4'b1111;
        end else begin
            sync1 <= col_n;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= SCAN;
            row_idx   <= 2'd0;
            row_n     <= 4'b1110;
            dwell_cnt <= '0;
            db_cnt    <= '0;
            cand_col  <= 4'b0000;
            R_val     <= 4'b0000;
            C         <= 4'b0000;
            key_press <= 1'b0;
            new_key   <= 1'b0;
        end else begin
            new_key <= 1'b0;
            case (state)
                SCAN: begin
                    if (dwell_cnt == DWELL_LAST) begin
                        if (col_single) begin
                            // Row stays put: row_idx doubles as the candidate row.
                            cand_col <= col_act;
                            db_cnt   <= '0;
                            state    <= DEBOUNCE;
                        end else begin
                            row_idx   <= row_idx + 2'd1;
                            row_n     <= row_drive(row_idx + 2'd1);
                            dwell_cnt <= '0;
                        end
                    end else begin
                        dwell_cnt <= dwell_cnt + DW'(1);
                    end
                end
                DEBOUNCE: begin
                    if (col_act != cand_col) begin
                        dwell_cnt <= '0;
                        state     <= SCAN;
                    end else if (db_cnt == DB_LAST) begin
                        R_val     <= 4'b0001 << row_idx;
                        C         <= cand_col;
                        new_key   <= 1'b1;
                        key_press <= 1'b1;
                        state     <= HELD;
                    end else begin
                        db_cnt <= db_cnt + BW'(1);
                    end
                end
                HELD: begin
                    // Other keys, even in this row, are ignored while held.
                    if (!cand_hit) begin
                        db_cnt <= '0;
                        state  <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (cand_hit) begin
                        state <= HELD;
                    end else if (db_cnt == DB_LAST) begin
                        row_idx   <= row_idx + 2'd1;
                        row_n     <= row_drive(row_idx + 2'd1);
                        dwell_cnt <= '0;
                        key_press <= 1'b0;
                        state     <= SCAN;
                    end else begin
                        db_cnt <= db_cnt + BW'(1);
                    end
                end
                default: state <= SCAN;
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: a keypad model closes row/column paths,
// expected key acceptances are queued by stimulus and matched by a monitor.
module tb_keypad_scanner;

    logic       clk;
    logic       reset;
    logic [3:0] col_n;
    logic [3:0] row_n;
    logic [3:0] R_val;
    logic [3:0] C;
    logic       key_press;
    logic       new_key;

    logic [3:0][3:0] keys;   // keys[row][col]

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] c;
    } exp_t;

    exp_t q[$];
    int   total;
    int   bad;
    bit   mon_en;

    keypad_scanner #(.SCAN_DIV(4), .DB_CYCLES(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .col_n     (col_n),
        .row_n     (row_n),
        .R_val     (R_val),
        .C         (C),
        .key_press (key_press),
        .new_key   (new_key)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        col_n = 4'b1111;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                if (!row_n[i] && keys[i][j]) col_n[j] = 1'b0;
    end

    // Monitor: row strobe sanity every cycle, and acceptances against the queue.
    always @(negedge clk) begin
        if (mon_en) begin
            total++;
            if ($countones(~row_n) != 1) begin
                bad++;
                $display("FAIL row_onehot act=%b req=exactly one low bit", row_n);
            end
            if (new_key) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_new_key act R_val=%b C=%b req=no pulse", R_val, C);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    if ({R_val, C} !== {e.r, e.c}) begin
                        bad++;
                        $display("FAIL accept_key act R_val=%b C=%b req R_val=%b C=%b",
                                 R_val, C, e.r, e.c);
                    end
                    total++;
                    if (key_press !== 1'b1) begin
                        bad++;
                        $display("FAIL accept_key_press act=%b req=1", key_press);
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s act=%b req=%b", name, act, req);
        end
    endtask

    task automatic expect_key(input logic [3:0] r, input logic [3:0] c);
        exp_t e;
        e.r = r;
        e.c = c;
        q.push_back(e);
    endtask

    // Wait for all queued acceptances to be seen, within a cycle budget.
    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while (q.size() != 0 && n < budget) begin
            tick(1);
            n++;
        end
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL %s act=%0d pending req=0 pending", name, q.size());
            q.delete();
        end
    endtask

    initial begin
        logic [3:0] seen;
        total  = 0;
        bad    = 0;
        mon_en = 1'b0;
        keys   = '0;
        reset  = 1'b0;

        // Reset and idle scan stepping.
        tick(3);
        mon_en = 1'b1;
        chk("rst_row_n", row_n, 4'b1110);
        chk("rst_R_val", R_val, 4'b0000);
        chk("rst_C", C, 4'b0000);
        chk("rst_key_press", {3'b000, key_press}, 4'b0000);
        chk("rst_new_key", {3'b000, new_key}, 4'b0000);
        reset = 1'b1;
        tick(4); chk("scan_row1", row_n, 4'b1101);
        tick(4); chk("scan_row2", row_n, 4'b1011);
        tick(4); chk("scan_row3", row_n, 4'b0111);
        tick(4); chk("scan_wrap", row_n, 4'b1110);

        // Clean press of key(2,1), then release.
        keys[2][1] = 1'b1;
        expect_key(4'b0100, 4'b0010);
        drain("clean_accept", 60);
        tick(40);
        chk("clean_held_kp", {3'b000, key_press}, 4'b0001);
        chk("clean_held_row", row_n, 4'b1011);
        keys[2][1] = 1'b0;
        tick(10);
        chk("clean_rel_kp_hi", {3'b000, key_press}, 4'b0001);
        tick(1);
        chk("clean_rel_kp_lo", {3'b000, key_press}, 4'b0000);
        tick(20);
        chk("clean_keep_R", R_val, 4'b0100);
        chk("clean_keep_C", C, 4'b0010);

        // Bouncing press of key(0,3), held, then bouncing release.
        expect_key(4'b0001, 4'b1000);
        for (int k = 0; k < 10; k++) begin
            keys[0][3] = ~k[0];
            tick(3);
        end
        keys[0][3] = 1'b1;
        drain("bounce_accept", 60);
        tick(20);
        chk("bounce_R", R_val, 4'b0001);
        chk("bounce_C", C, 4'b1000);
        for (int k = 0; k < 10; k++) begin
            keys[0][3] = k[0];
            tick(3);
        end
        keys[0][3] = 1'b0;
        tick(30);
        chk("bounce_rel_kp", {3'b000, key_press}, 4'b0000);

        // Two keys in one row: never accepted, scan keeps wrapping.
        keys[1][0] = 1'b1;
        keys[1][2] = 1'b1;
        seen = 4'b0000;
        for (int k = 0; k < 60; k++) begin
            tick(1);
            seen = seen | ~row_n;
        end
        chk("multi_rows_seen", seen, 4'b1111);
        chk("multi_kp", {3'b000, key_press}, 4'b0000);
        chk("multi_keep_C", C, 4'b1000);
        keys[1][0] = 1'b0;
        keys[1][2] = 1'b0;
        tick(20);

        // Second key while held: no rollover.
        keys[3][1] = 1'b1;
        expect_key(4'b1000, 4'b0010);
        drain("held_accept", 60);
        tick(10);
        keys[0][0] = 1'b1;
        keys[3][2] = 1'b1;
        tick(60);
        chk("held2_R", R_val, 4'b1000);
        chk("held2_C", C, 4'b0010);
        chk("held2_kp", {3'b000, key_press}, 4'b0001);
        chk("held2_row", row_n, 4'b0111);
        keys = '0;
        tick(30);
        chk("held2_rel_kp", {3'b000, key_press}, 4'b0000);

        // Reset while a key is held, key stays down and is re-accepted.
        keys[1][3] = 1'b1;
        expect_key(4'b0010, 4'b1000);
        drain("mid_accept", 60);
        tick(10);
        chk("mid_pre_kp", {3'b000, key_press}, 4'b0001);
        reset = 1'b0;
        tick(1);
        chk("mid_rst_kp", {3'b000, key_press}, 4'b0000);
        chk("mid_rst_R", R_val, 4'b0000);
        chk("mid_rst_C", C, 4'b0000);
        chk("mid_rst_row", row_n, 4'b1110);
        reset = 1'b1;
        expect_key(4'b0010, 4'b1000);
        drain("mid_reaccept", 60);
        tick(10);
        keys = '0;
        tick(30);
        chk("final_kp", {3'b000, key_press}, 4'b0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
